fa_nbit_rca: RTL and testbench
==============================

Name: fa_nbit_rca

Overview:
- Parameterised SIZE-bit ripple-carry adder: a chain of SIZE one-bit full-adder cells, with the carry of bit i feeding bit i+1.
- Sum, carry-out and signed-overflow outputs are captured in output registers, giving one clock of latency.
- Used as the generic adder primitive in the arithmetic datapath. Width is set at instantiation.

Parameters:
- SIZE, default 2: operand and sum width in bits; legal range 1..64.

Ports:
- PortClk_nbit  input  1  clock; all state updates on the rising edge.
- PortRst_nbit  input  1  reset; synchronous, active-high.
- PortA_nbit  input  SIZE  operand A, unsigned or two's complement.
- PortB_nbit  input  SIZE  operand B, unsigned or two's complement.
- PortCin_nbit  input  1  carry-in to bit 0.
- PortS_nbit  output  SIZE  registered sum, bits [SIZE-1:0].
- PortCout_nbit  output  1  registered carry-out of bit SIZE-1.
- PortOvf_nbit  output  1  registered signed overflow flag.

Behaviour:
- Full-adder cell i, for i = 0..SIZE-1:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]))
  - c[0] = PortCin_nbit
- Structure: cells are instantiated with a generate loop as an explicit ripple chain. Lookahead or a behavioural "+" is not allowed in the adder core.
- Combinational results:
  - {cout, s} = A + B + Cin, exactly (SIZE+1)-bit, with no truncation beyond S.
  - ovf = c[SIZE] ^ c[SIZE-1]. For SIZE=1, ovf = c[1] ^ c[0].
- Registers: on each rising edge of PortClk_nbit:
  - if PortRst_nbit = 1: PortS_nbit <= 0, PortCout_nbit <= 0, PortOvf_nbit <= 0;
  - else: PortS_nbit <= s, PortCout_nbit <= cout, PortOvf_nbit <= ovf.
- Latency: exactly 1 cycle from the input edge to the registered result. No handshake; a new operand set is accepted every cycle (full throughput).
- Reset priority: reset overrides data. If reset is asserted mid-stream, the outputs read 0 on the following edge. After deassertion, the first valid result appears one edge after the inputs are sampled.
- Power-up value before the first reset is don't-care. Verification checks outputs only after one reset cycle.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.
- Wrap-around:
  - all-ones + all-ones + 1 -> S = all-ones, Cout = 1;
  - all-ones + 0 + 1 -> S = 0, Cout = 1.

Test Plan:
- Reset: hold PortRst_nbit=1 with A=3, B=3, Cin=1 (SIZE=2) -> after the edge, S=0, Cout=0, Ovf=0. Deassert -> the next edge gives S=3, Cout=1, Ovf=0.
- Exhaustive, SIZE=2: Cin in {0,1}, A in 0..3, B in 0..3 (32 cases), one per cycle -> each result one cycle later satisfies {Cout,S} = A+B+Cin. Example: A=2, B=3, Cin=0 -> S=1, Cout=1.
- Signed overflow, SIZE=2:
  - A=1, B=1, Cin=0 -> S=2, Cout=0, Ovf=1;
  - A=2, B=2, Cin=0 -> S=0, Cout=1, Ovf=1;
  - A=3, B=1, Cin=0 -> S=0, Cout=1, Ovf=0.
- Full ripple, SIZE=8: A=0xFF, B=0x00, Cin=1 -> S=0x00, Cout=1, Ovf=0. A=0x7F, B=0x00, Cin=1 -> S=0x80, Cout=0, Ovf=1.
- Throughput/latency, SIZE=4: back-to-back (5,6,0), (15,15,1), (8,8,0) on consecutive cycles -> outputs on consecutive cycles S=11/Cout=0, S=15/Cout=1, S=0/Cout=1/Ovf=1.
- Mid-stream reset: assert reset for one cycle inside the sequence above -> that cycle's output is 0, and the stream resumes correctly on the next cycle.

Source files
------------

// File: rtl/fa_nbit_rca_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives the operands and carry-in; the slave returns the registered sum and flags.
interface fa_nbit_rca_if #(
   parameter int SIZE = 2
);
   logic [SIZE-1:0] PortA_nbit;
   logic [SIZE-1:0] PortB_nbit;
   logic            PortCin_nbit;
   logic [SIZE-1:0] PortS_nbit;
   logic            PortCout_nbit;
   logic            PortOvf_nbit;

   modport master (
      output PortA_nbit, PortB_nbit, PortCin_nbit,
      input  PortS_nbit, PortCout_nbit, PortOvf_nbit
   );

   modport slave (
      input  PortA_nbit, PortB_nbit, PortCin_nbit,
      output PortS_nbit, PortCout_nbit, PortOvf_nbit
   );
endinterface

// File: rtl/fa_nbit_rca.sv
// SIZE-bit ripple-carry adder built from a chain of one-bit full-adder cells,
// with sum, carry-out and signed overflow registered for one cycle of latency.
module fa_nbit_cell (
   input  logic a,
   input  logic b,
   input  logic cIn,
   output logic s,
   output logic cOut
);
   assign s    = a ^ b ^ cIn;
   assign cOut = (a & b) | (cIn & (a ^ b));
endmodule

module fa_nbit_rca #(
   parameter int SIZE = 2
) (
   input logic           PortClk_nbit,
   input logic           PortRst_nbit,
   fa_nbit_rca_if.slave  bus
);
   logic [SIZE:0]   carry_p0;
   logic [SIZE-1:0] sum_p0;
   logic            ovf_p0;

   assign carry_p0[0] = bus.PortCin_nbit;

   for (genvar i = 0; i < SIZE; i++) begin : gCell
      fa_nbit_cell uCell (
         .a    (bus.PortA_nbit[i]),
         .b    (bus.PortB_nbit[i]),
         .cIn  (carry_p0[i]),
         .s    (sum_p0[i]),
         .cOut (carry_p0[i+1])
      );
   end

   // Signed overflow: carries into and out of the sign bit disagree.
   assign ovf_p0 = carry_p0[SIZE] ^ carry_p0[SIZE-1];

   // Stage p0 -> p1: output registers, reset overrides data.
   always_ff @(posedge PortClk_nbit) begin
      if (PortRst_nbit) begin
         bus.PortS_nbit    <= '0;
         bus.PortCout_nbit <= 1'b0;
         bus.PortOvf_nbit  <= 1'b0;
      end else begin
         bus.PortS_nbit    <= sum_p0;
         bus.PortCout_nbit <= carry_p0[SIZE];
         bus.PortOvf_nbit  <= ovf_p0;
      end
   end
endmodule

// File: tb/tb_fa_nbit_rca.sv
// Randomized and directed bench for fa_nbit_rca at SIZE 2, 4 and 8,
// checked against an arithmetic reference model.
module tb_fa_nbit_rca;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   fa_nbit_rca_if #(.SIZE(2)) bus2 ();
   fa_nbit_rca_if #(.SIZE(4)) bus4 ();
   fa_nbit_rca_if #(.SIZE(8)) bus8 ();

   fa_nbit_rca #(.SIZE(2)) uDut2 (.PortClk_nbit(clk), .PortRst_nbit(rst), .bus(bus2.slave));
   fa_nbit_rca #(.SIZE(4)) uDut4 (.PortClk_nbit(clk), .PortRst_nbit(rst), .bus(bus4.slave));
   fa_nbit_rca #(.SIZE(8)) uDut8 (.PortClk_nbit(clk), .PortRst_nbit(rst), .bus(bus8.slave));

   // Reference: unsigned sum for S/Cout, signed range check for overflow.
   function automatic logic [9:0] model(input int n, input int a, input int b, input int cin);
      longint full, sa, sb, ssum, lim;
      logic [9:0] r;
      full = longint'(a) + longint'(b) + longint'(cin);
      lim  = longint'(1) << (n - 1);
      sa   = (a >= lim) ? a - 2 * lim : a;
      sb   = (b >= lim) ? b - 2 * lim : b;
      ssum = sa + sb + cin;
      r    = '0;
      r[7:0] = 8'(full % (2 * lim));
      r[8]   = (full >= 2 * lim);
      r[9]   = (ssum > lim - 1) || (ssum < -lim);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [9:0] obs, exp;
      rst = 1'b1;
      bus2.PortA_nbit = 2'd3; bus2.PortB_nbit = 2'd3; bus2.PortCin_nbit = 1'b1;
      tick();
      obs = {bus2.PortOvf_nbit, bus2.PortCout_nbit, 6'd0, bus2.PortS_nbit};
      compared++;
      if (obs !== 10'd0) begin
         mismatched++;
         $display("FAIL reset_hold got=%h want=%h", obs, 10'd0);
      end
      rst = 1'b0;
      tick();
      obs = {bus2.PortOvf_nbit, bus2.PortCout_nbit, 6'd0, bus2.PortS_nbit};
      exp = {1'b0, 1'b1, 8'd3};
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL reset_release got=%h want=%h", obs, exp);
      end
   endtask

   task automatic test_exhaustive2();
      logic [9:0] obs, exp;
      for (int c = 0; c < 2; c++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
               bus2.PortA_nbit = 2'(a); bus2.PortB_nbit = 2'(b); bus2.PortCin_nbit = 1'(c);
               tick();
               obs = {bus2.PortOvf_nbit, bus2.PortCout_nbit, 6'd0, bus2.PortS_nbit};
               exp = model(2, a, b, c);
               compared++;
               if (obs !== exp) begin
                  mismatched++;
                  $display("FAIL exh2 a=%0d b=%0d cin=%0d got=%h want=%h", a, b, c, obs, exp);
               end
            end
   endtask

   task automatic test_overflow2();
      int         va [3] = '{1, 2, 3};
      int         vb [3] = '{1, 2, 1};
      logic [9:0] ve [3] = '{{2'b10, 8'd2}, {2'b11, 8'd0}, {2'b01, 8'd0}};
      logic [9:0] obs;
      for (int k = 0; k < 3; k++) begin
         bus2.PortA_nbit = 2'(va[k]); bus2.PortB_nbit = 2'(vb[k]); bus2.PortCin_nbit = 1'b0;
         tick();
         obs = {bus2.PortOvf_nbit, bus2.PortCout_nbit, 6'd0, bus2.PortS_nbit};
         compared++;
         if (obs !== ve[k]) begin
            mismatched++;
            $display("FAIL ovf2_%0d got=%h want=%h", k, obs, ve[k]);
         end
      end
   endtask

   task automatic test_ripple8();
      logic [9:0] obs, exp;
      int a, b, c;
      for (int k = 0; k < 24; k++) begin
         case (k)
            0:       begin a = 255; b = 0;   c = 1; exp = {2'b01, 8'h00}; end
            1:       begin a = 127; b = 0;   c = 1; exp = {2'b10, 8'h80}; end
            2:       begin a = 255; b = 255; c = 1; exp = {2'b01, 8'hFF}; end
            default: begin
               a = int'($urandom_range(255)); b = int'($urandom_range(255));
               c = int'($urandom_range(1));   exp = model(8, a, b, c);
            end
         endcase
         bus8.PortA_nbit = 8'(a); bus8.PortB_nbit = 8'(b); bus8.PortCin_nbit = 1'(c);
         tick();
         obs = {bus8.PortOvf_nbit, bus8.PortCout_nbit, bus8.PortS_nbit};
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("FAIL rip8 a=%0d b=%0d cin=%0d got=%h want=%h", a, b, c, obs, exp);
         end
      end
   endtask

   task automatic test_back_to_back4();
      int         va [3] = '{5, 15, 8};
      int         vb [3] = '{6, 15, 8};
      int         vc [3] = '{0, 1, 0};
      logic [9:0] ve [3] = '{{2'b10, 8'd11}, {2'b01, 8'd15}, {2'b11, 8'd0}};
      logic [9:0] obs, exp;
      int a, b, c;
      for (int k = 0; k < 3; k++) begin
         bus4.PortA_nbit = 4'(va[k]); bus4.PortB_nbit = 4'(vb[k]); bus4.PortCin_nbit = 1'(vc[k]);
         tick();
         obs = {bus4.PortOvf_nbit, bus4.PortCout_nbit, 4'd0, bus4.PortS_nbit};
         compared++;
         if (obs !== ve[k]) begin
            mismatched++;
            $display("FAIL b2b4_%0d got=%h want=%h", k, obs, ve[k]);
         end
      end
      for (int k = 0; k < 20; k++) begin
         a = int'($urandom_range(15)); b = int'($urandom_range(15)); c = int'($urandom_range(1));
         bus4.PortA_nbit = 4'(a); bus4.PortB_nbit = 4'(b); bus4.PortCin_nbit = 1'(c);
         tick();
         obs = {bus4.PortOvf_nbit, bus4.PortCout_nbit, 4'd0, bus4.PortS_nbit};
         exp = model(4, a, b, c);
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("FAIL rnd4 a=%0d b=%0d cin=%0d got=%h want=%h", a, b, c, obs, exp);
         end
      end
   endtask

   task automatic test_midreset4();
      int         va [3] = '{5, 15, 8};
      int         vb [3] = '{6, 15, 8};
      int         vc [3] = '{0, 1, 0};
      logic [9:0] ve [3] = '{{2'b10, 8'd11}, 10'd0, {2'b11, 8'd0}};
      logic [9:0] obs;
      for (int k = 0; k < 3; k++) begin
         rst = (k == 1);
         bus4.PortA_nbit = 4'(va[k]); bus4.PortB_nbit = 4'(vb[k]); bus4.PortCin_nbit = 1'(vc[k]);
         tick();
         obs = {bus4.PortOvf_nbit, bus4.PortCout_nbit, 4'd0, bus4.PortS_nbit};
         compared++;
         if (obs !== ve[k]) begin
            mismatched++;
            $display("FAIL midrst4_%0d got=%h want=%h", k, obs, ve[k]);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      bus2.PortA_nbit = '0; bus2.PortB_nbit = '0; bus2.PortCin_nbit = 1'b0;
      bus4.PortA_nbit = '0; bus4.PortB_nbit = '0; bus4.PortCin_nbit = 1'b0;
      bus8.PortA_nbit = '0; bus8.PortB_nbit = '0; bus8.PortCin_nbit = 1'b0;
      tick();
      tick();
      test_reset();
      test_exhaustive2();
      test_overflow2();
      test_ripple8();
      test_back_to_back4();
      test_midreset4();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
